// File: rtl/rst_seq.sv
// Staged reset release sequencer: synchronises rst_n deassertion to clk_12m, then releases
// N_STAGES reset domains in ascending order. Define RST_SEQ_SOFT_EN to build the soft re-reset handshake.
module rst_seq #(
    parameter int N_STAGES    = 3,
    parameter int STAGE_DELAY = 64,
    parameter int SYNC_DEPTH  = 2,
    parameter int SOFT_HOLD   = 16
) (
    input  logic                clk_12m,
    input  logic                rst_n,
    input  logic                soft_req,
    output logic                soft_ack,
    output logic [N_STAGES-1:0] rst_stage,
    output logic                all_ready
);

    localparam int MAX_CNT = (STAGE_DELAY > SOFT_HOLD) ? STAGE_DELAY : SOFT_HOLD;
    localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam int IW      = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

    localparam logic [CW-1:0] DLY_TC     = CW'(STAGE_DELAY - 1);
    localparam logic [IW-1:0] LAST_STAGE = IW'(N_STAGES - 1);
`ifdef RST_SEQ_SOFT_EN
    localparam logic [CW-1:0] HOLD_TC    = CW'(SOFT_HOLD - 1);
`endif

`ifdef RST_SEQ_SOFT_EN
    typedef enum logic [1:0] {S_RESET, S_RELEASE, S_RUN, S_SOFT_ASSERT} state_t;
`else
    typedef enum logic [1:0] {S_RESET, S_RELEASE, S_RUN} state_t;
    logic unused_soft_req;
    assign unused_soft_req = soft_req;
`endif

    state_t                state_q;
    logic [SYNC_DEPTH-1:0] sync_q;
    logic [CW-1:0]         cnt_q;
    logic [IW-1:0]         idx_q;
    logic [N_STAGES-1:0]   rst_stage_q;
    logic                  all_ready_q;
    logic                  soft_ack_q;
    logic [N_STAGES-1:0]   stage_clr_d;

    // One-hot mask of the stage that the current index releases.
    always_comb begin
        stage_clr_d = '0;
        for (int i = 0; i < N_STAGES; i++) begin
            stage_clr_d[i] = (idx_q == IW'(i));
        end
    end

    always_ff @(posedge clk_12m or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RESET;
            sync_q      <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            rst_stage_q <= '1;
            all_ready_q <= 1'b0;
            soft_ack_q  <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_DEPTH-2:0], 1'b1};
            soft_ack_q <= 1'b0;
            case (state_q)
                S_RESET: begin
                    if (sync_q[SYNC_DEPTH-1]) begin
                        state_q <= S_RELEASE;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                    end
                end
                S_RELEASE: begin
                    if (cnt_q == DLY_TC) begin
                        cnt_q       <= '0;
                        idx_q       <= idx_q + IW'(1);
                        rst_stage_q <= rst_stage_q & ~stage_clr_d;
                        if (idx_q == LAST_STAGE) begin
                            all_ready_q <= 1'b1;
                            state_q     <= S_RUN;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_RUN: begin
`ifdef RST_SEQ_SOFT_EN
                    if (soft_req) begin
                        state_q     <= S_SOFT_ASSERT;
                        rst_stage_q <= '1;
                        all_ready_q <= 1'b0;
                        cnt_q       <= '0;
                        soft_ack_q  <= 1'b1;
                    end
`endif
                end
`ifdef RST_SEQ_SOFT_EN
                S_SOFT_ASSERT: begin
                    if (cnt_q == HOLD_TC) begin
                        state_q <= S_RELEASE;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
`endif
                default: state_q <= S_RESET;
            endcase
        end
    end

    assign rst_stage = rst_stage_q;
    assign all_ready = all_ready_q;
    assign soft_ack  = soft_ack_q;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq: default-parameter instance plus a minimal-delay stress instance.
module tb_rst_seq;

    logic       clk_12m = 1'b0;
    logic       rst_n   = 1'b0;
    logic       soft_req  = 1'b0;
    logic       soft_req2 = 1'b0;
    logic       soft_ack, soft_ack2;
    logic [2:0] rst_stage;
    logic [0:0] rst_stage2;
    logic       all_ready, all_ready2;

    int checks   = 0;
    int failures = 0;
    int ecnt     = 0;

    always #5 clk_12m = ~clk_12m;

    rst_seq dut (
        .clk_12m   (clk_12m),
        .rst_n     (rst_n),
        .soft_req  (soft_req),
        .soft_ack  (soft_ack),
        .rst_stage (rst_stage),
        .all_ready (all_ready)
    );

    rst_seq #(.N_STAGES(1), .STAGE_DELAY(1), .SYNC_DEPTH(2), .SOFT_HOLD(1)) dut2 (
        .clk_12m   (clk_12m),
        .rst_n     (rst_n),
        .soft_req  (soft_req2),
        .soft_ack  (soft_ack2),
        .rst_stage (rst_stage2),
        .all_ready (all_ready2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after rising edge number e (counted from rst_n release).
    task automatic goto_edge(input int e);
        while (ecnt < e) begin
            @(posedge clk_12m);
            ecnt++;
        end
        #1;
    endtask

    initial begin
        // Power-up
        repeat (10) @(negedge clk_12m);
        chk("rst_stage_in_reset", rst_stage, 3'b111);
        chk("all_ready_in_reset", all_ready, 1'b0);
        chk("soft_ack_in_reset", soft_ack, 1'b0);
        chk("stress_in_reset", rst_stage2, 1'b1);
        rst_n = 1'b1;
        ecnt  = 0;

        goto_edge(3);
        chk("stress_stage_e3", rst_stage2, 1'b1);
        chk("stress_ready_e3", all_ready2, 1'b0);
        goto_edge(4);
        chk("stress_stage_e4", rst_stage2, 1'b0);
        chk("stress_ready_e4", all_ready2, 1'b1);

        goto_edge(66);
        chk("stage_e66", rst_stage, 3'b111);
        goto_edge(67);
        chk("stage_e67", rst_stage, 3'b110);
        goto_edge(100);
        soft_req = 1'b1;
        goto_edge(130);
        chk("stage_e130", rst_stage, 3'b110);
        goto_edge(131);
        chk("stage_e131", rst_stage, 3'b100);
        chk("ack_e131", soft_ack, 1'b0);
        goto_edge(194);
        chk("stage_e194", rst_stage, 3'b100);
        chk("ready_e194", all_ready, 1'b0);
        goto_edge(195);
        chk("stage_e195", rst_stage, 3'b000);
        chk("ready_e195", all_ready, 1'b1);
        chk("ack_e195", soft_ack, 1'b0);

`ifdef RST_SEQ_SOFT_EN
        goto_edge(196);
        chk("ack_e196", soft_ack, 1'b1);
        chk("soft_stage_e196", rst_stage, 3'b111);
        chk("soft_ready_e196", all_ready, 1'b0);
        soft_req = 1'b0;
        goto_edge(197);
        chk("ack_e197", soft_ack, 1'b0);
        goto_edge(275);
        chk("soft_stage_e275", rst_stage, 3'b111);
        goto_edge(276);
        chk("soft_stage_e276", rst_stage, 3'b110);
        goto_edge(340);
        chk("soft_stage_e340", rst_stage, 3'b100);
        goto_edge(403);
        chk("soft_ready_e403", all_ready, 1'b0);
        goto_edge(404);
        chk("soft_stage_e404", rst_stage, 3'b000);
        chk("soft_ready_e404", all_ready, 1'b1);
        chk("soft_ack_e404", soft_ack, 1'b0);
`else
        for (int e = 196; e < 1196; e++) begin
            goto_edge(e);
            chk("noack_run", soft_ack, 1'b0);
            chk("stage_run", rst_stage, 3'b000);
        end
        soft_req = 1'b0;
`endif

        // Reset mid-sequence
        @(negedge clk_12m);
        rst_n = 1'b0;
        repeat (3) @(negedge clk_12m);
        rst_n = 1'b1;
        ecnt  = 0;
        goto_edge(10);
`ifdef RST_SEQ_SOFT_EN
        soft_req2 = 1'b1;
        goto_edge(11);
        chk("stress_ack_e11", soft_ack2, 1'b1);
        chk("stress_stage_e11", rst_stage2, 1'b1);
        chk("stress_ready_e11", all_ready2, 1'b0);
        soft_req2 = 1'b0;
        goto_edge(12);
        chk("stress_ack_e12", soft_ack2, 1'b0);
        chk("stress_stage_e12", rst_stage2, 1'b1);
        goto_edge(13);
        chk("stress_stage_e13", rst_stage2, 1'b0);
        chk("stress_ready_e13", all_ready2, 1'b1);
`else
        chk("stress_noack_e10", soft_ack2, 1'b0);
`endif
        goto_edge(100);
        chk("mid_stage_e100", rst_stage, 3'b110);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_stage", rst_stage, 3'b111);
        chk("async_ready", all_ready, 1'b0);
        chk("async_stress", rst_stage2, 1'b1);
        repeat (4) @(negedge clk_12m);
        rst_n = 1'b1;
        ecnt  = 0;
        goto_edge(66);
        chk("rerun_stage_e66", rst_stage, 3'b111);
        goto_edge(67);
        chk("rerun_stage_e67", rst_stage, 3'b110);
        goto_edge(131);
        chk("rerun_stage_e131", rst_stage, 3'b100);
        goto_edge(195);
        chk("rerun_stage_e195", rst_stage, 3'b000);
        chk("rerun_ready_e195", all_ready, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rst_seq.md
# rst_seq

Staged reset release sequencer. It sits downstream of the system manager in the clocked domain. It takes the global asynchronous active-low reset, synchronises its deassertion to `clk_12m`, and then releases up to eight downstream reset domains one at a time in a fixed order. When `RST_SEQ_SOFT_EN` is defined, the block also lets user logic request a full soft re-reset through a request/acknowledge handshake.

## Interface
- `N_STAGES`, default 3: number of reset domains; legal range 1..8.
- `STAGE_DELAY`, default 64: clock cycles between successive stage releases; must be ≥1.
- `SYNC_DEPTH`, default 2: depth of the deassertion synchroniser; must be ≥2.
- `SOFT_HOLD`, default 16: cycles that all stages are held in reset after a soft request; must be ≥1.
- `clk_12m`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `soft_req`  in  1  soft-reset request, level; held high by the requester until it sees `soft_ack`.
- `soft_ack`  out  1  one-cycle pulse; the soft request has been accepted.
- `rst_stage`  out  N_STAGES  active-high reset per domain; bit 0 is released first.
- `all_ready`  out  1  high when every stage is released.

## Operation
- States: RESET, RELEASE, RUN, SOFT_ASSERT.
- **While `rst_n` is low (asynchronous):**
  - state = RESET; synchroniser flops = 0; counter = 0; stage index = 0.
  - `rst_stage` = all ones; `all_ready` = 0; `soft_ack` = 0.
  - These values take effect immediately, including mid-sequence or mid-soft-reset.
- **RESET:**
  - Constant 1 shifts through the `SYNC_DEPTH`-flop chain.
  - On the edge where the last flop is already 1, go to RELEASE with counter = 0 and stage index = 0.
- **RELEASE:**
  - Counter runs 0..STAGE_DELAY-1.
  - On the terminal-count edge: clear `rst_stage[index]`, reset counter to 0, increment index.
  - On the edge that clears bit N_STAGES-1: set `all_ready`=1 and go to RUN.
  - Stages release in strict ascending order; a lower bit is never set again while a higher bit is clear.
- **RUN:**
  - Outputs are static.
  - If `soft_req`=1 on an edge, go to SOFT_ASSERT on that edge: `rst_stage` = all ones, `all_ready`=0, counter = 0, and `soft_ack`=1 for exactly the following cycle.
- **SOFT_ASSERT:**
  - Counter runs 0..SOFT_HOLD-1.
  - On the terminal edge, go to RELEASE with counter = 0 and index = 0.
- **Outside RUN, `soft_req` is ignored:** no ack is issued and the request is not queued. A request still held high is accepted on the first RUN edge.
- If `soft_req` stays high after `soft_ack`, another soft reset starts on re-entering RUN. The requester must drop `soft_req` after the ack.
- The counter is `$clog2(max(STAGE_DELAY,SOFT_HOLD))` bits wide (minimum 1) and never wraps; it is always reloaded at terminal count.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Timing
- Edge numbering: edge 1 is the first rising `clk_12m` edge after `rst_n` rises (setup met).
- With `SYNC_DEPTH`=D, RELEASE is entered at edge R = D+1.
- Stage k deasserts at edge R + (k+1)·STAGE_DELAY.
- `all_ready` rises on the same edge as the last stage deasserts.
- Soft path: request sampled at edge E → `rst_stage` all ones after E; RELEASE entered at E+SOFT_HOLD; stage k deasserts at E+SOFT_HOLD+(k+1)·STAGE_DELAY.
- Reset assertion is asynchronous; only deassertion is synchronous.

## Configuration
- `RST_SEQ_SOFT_EN` defined: SOFT_ASSERT state and the handshake are built.
- `RST_SEQ_SOFT_EN` undefined:
  - SOFT_ASSERT state is removed and `soft_req` is unused.
  - `soft_ack` is tied to 0.
  - RUN is terminal until `rst_n` is asserted.

## Test plan
All scenarios use default parameters.
- **Power-up:** hold `rst_n` low for 10 cycles, then release → `rst_stage`=3'b111 through edge 66; 3'b110 at edge 67; 3'b100 at edge 131; 3'b000 and `all_ready`=1 at edge 195.
- **Reset mid-sequence:** assert `rst_n` low between edges 100 and 101 → `rst_stage`=3'b111 and `all_ready`=0 immediately, with no clock. After release, the full sequence repeats from edge 1 (stage 0 at edge 67).
- **Soft reset (macro defined):** in RUN, `soft_req`=1 sampled at edge E → `soft_ack` high for one cycle after E, `rst_stage`=3'b111, `all_ready`=0. Stage 0 releases at E+80, stage 1 at E+144, stage 2 at E+208.
- **Request outside RUN:** hold `soft_req` high from edge 100 → no `soft_ack` before RUN is entered at edge 195; ack follows the sample at edge 196.
- **Macro undefined:** hold `soft_req`=1 throughout RUN for 1000 cycles → `soft_ack`=0 and `rst_stage`=3'b000 constantly.
- **Stress:** N_STAGES=1, STAGE_DELAY=1, SOFT_HOLD=1 → stage 0 and `all_ready` change at edge 4; a soft request at E gives release at E+2.
